// File: rtl/ibex_rf_cache_pkg.sv
// Shared types for the cached register file: fill FSM states, cache entry layout, x0 constant.
// Optional hit/miss counters are compiled in with IBEX_RF_CACHE_PERF_EN.
package ibex_rf_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_A = 2'd1,
    FILL_B = 2'd2
  } rf_cache_state_e;

  localparam int unsigned RfMaxDataWidth = 32;
  localparam logic [4:0]  RegX0          = 5'd0;

  typedef struct packed {
    logic                      valid;
    logic [4:0]                tag;
    logic [RfMaxDataWidth-1:0] data;
  } rf_cache_entry_t;

  // RV32E has 16 registers; address bit 4 is ignored so x16..x31 alias x0..x15.
  function automatic logic [4:0] rf_norm_addr(input logic [4:0] addr, input bit rv32e);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_cache_tag_cam.sv
// Fully associative tag/valid/data array: two combinational lookup ports, a write-through
// update-by-tag port, an allocate-by-index port and a flush that clears every valid bit.
module ibex_rf_cache_tag_cam
  import ibex_rf_cache_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned CacheEntries = 4,
  localparam int unsigned IdxW        = $clog2(CacheEntries)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_flush,
  input  logic [4:0]           i_tag_a,
  output logic                 o_hit_a,
  output logic [DataWidth-1:0] o_data_a,
  input  logic [4:0]           i_tag_b,
  output logic                 o_hit_b,
  output logic [DataWidth-1:0] o_data_b,
  input  logic                 i_upd_en,
  input  logic [4:0]           i_upd_tag,
  input  logic [DataWidth-1:0] i_upd_data,
  input  logic                 i_alloc_en,
  input  logic [IdxW-1:0]      i_alloc_idx,
  input  logic [4:0]           i_alloc_tag,
  input  logic [DataWidth-1:0] i_alloc_data
);

  rf_cache_entry_t r_entries [CacheEntries];

  // Tags are unique, so at most one entry matches per port.
  always_comb begin
    o_hit_a  = 1'b0;
    o_data_a = '0;
    o_hit_b  = 1'b0;
    o_data_b = '0;
    for (int i = 0; i < CacheEntries; i++) begin
      if (r_entries[i].valid && (r_entries[i].tag == i_tag_a)) begin
        o_hit_a  = 1'b1;
        o_data_a = DataWidth'(r_entries[i].data);
      end
      if (r_entries[i].valid && (r_entries[i].tag == i_tag_b)) begin
        o_hit_b  = 1'b1;
        o_data_b = DataWidth'(r_entries[i].data);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CacheEntries; i++) r_entries[i] <= '0;
    end else begin
      for (int i = 0; i < CacheEntries; i++) begin
        if (i_flush) begin
          r_entries[i].valid <= 1'b0;
        end else if (i_alloc_en && (i_alloc_idx == IdxW'(i))) begin
          r_entries[i] <= '{valid: 1'b1, tag: i_alloc_tag, data: RfMaxDataWidth'(i_alloc_data)};
        end else if (i_upd_en && r_entries[i].valid && (r_entries[i].tag == i_upd_tag)) begin
          r_entries[i].data <= RfMaxDataWidth'(i_upd_data);
        end
      end
    end
  end

endmodule

// File: rtl/ibex_regfile_cached.sv
// Register file with write-through backing store and a round-robin read cache; read misses
// stall ID for a fixed fill latency. Define IBEX_RF_CACHE_PERF_EN to add hit/miss counters.
module ibex_regfile_cached
  import ibex_rf_cache_pkg::*;
#(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned CacheEntries = 4,
  parameter int unsigned MissLatency  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 re_a_i,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic                 re_b_i,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic                 we_a_i,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 flush_i,
  output logic                 stall_o,
`ifdef IBEX_RF_CACHE_PERF_EN
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o,
`endif
  output rf_cache_state_e      dbg_state_o
);

  localparam int unsigned NumRegs = RV32E ? 16 : 32;
  localparam int unsigned AddrW   = RV32E ? 4 : 5;
  localparam int unsigned IdxW    = $clog2(CacheEntries);
  localparam int unsigned CntW    = (MissLatency > 1) ? $clog2(MissLatency) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MissLatency - 1);

  if ((CacheEntries < 2) || ((CacheEntries & (CacheEntries - 1)) != 0)) begin : g_bad_entries
    $error("CacheEntries must be a power of 2 and at least 2");
  end
  if (MissLatency < 1) begin : g_bad_latency
    $error("MissLatency must be at least 1");
  end
  if ((DataWidth < 1) || (DataWidth > RfMaxDataWidth)) begin : g_bad_width
    $error("DataWidth out of range");
  end

  logic [DataWidth-1:0] r_mem [NumRegs];
  rf_cache_state_e      r_state, w_state_nxt;
  logic [CntW-1:0]      r_cnt, w_cnt_nxt;
  logic [4:0]           r_fill_addr, w_fill_addr_nxt;
  logic [IdxW-1:0]      r_victim;

  logic [4:0]           w_addr_a, w_addr_b, w_waddr;
  logic                 w_rd_a_en, w_rd_b_en, w_we;
  logic                 w_hit_a, w_hit_b, w_miss_a, w_miss_b;
  logic [DataWidth-1:0] w_cam_data_a, w_cam_data_b, w_fill_data;
  logic                 w_fill_done, w_alloc_en;

  assign w_addr_a  = rf_norm_addr(raddr_a_i, RV32E);
  assign w_addr_b  = rf_norm_addr(raddr_b_i, RV32E);
  assign w_waddr   = rf_norm_addr(waddr_a_i, RV32E);
  assign w_rd_a_en = re_a_i && (w_addr_a != RegX0);
  assign w_rd_b_en = re_b_i && (w_addr_b != RegX0);
  assign w_we      = we_a_i && (w_waddr != RegX0);
  assign w_miss_a  = w_rd_a_en && !w_hit_a;
  assign w_miss_b  = w_rd_b_en && !w_hit_b;
  assign rdata_a_o = (w_rd_a_en && w_hit_a) ? w_cam_data_a : '0;
  assign rdata_b_o = (w_rd_b_en && w_hit_b) ? w_cam_data_b : '0;

  // A write landing on the fill address in the completion cycle must win over the stale store.
  assign w_fill_done = (r_state != IDLE) && (r_cnt == '0);
  assign w_fill_data = (w_we && (w_waddr == r_fill_addr)) ? wdata_a_i
                                                          : r_mem[r_fill_addr[AddrW-1:0]];
  assign w_alloc_en  = w_fill_done && !flush_i;

  ibex_rf_cache_tag_cam #(
    .DataWidth   (DataWidth),
    .CacheEntries(CacheEntries)
  ) u_tag_cam (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_flush     (flush_i),
    .i_tag_a     (w_addr_a),
    .o_hit_a     (w_hit_a),
    .o_data_a    (w_cam_data_a),
    .i_tag_b     (w_addr_b),
    .o_hit_b     (w_hit_b),
    .o_data_b    (w_cam_data_b),
    .i_upd_en    (w_we),
    .i_upd_tag   (w_waddr),
    .i_upd_data  (wdata_a_i),
    .i_alloc_en  (w_alloc_en),
    .i_alloc_idx (r_victim),
    .i_alloc_tag (r_fill_addr),
    .i_alloc_data(w_fill_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[w_waddr[AddrW-1:0]] <= wdata_a_i;
    end
  end

  // The B fill is skipped when it targets the address the A fill just allocated.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_fill_addr_nxt = r_fill_addr;
    stall_o         = 1'b0;
    case (r_state)
      IDLE: begin
        stall_o = w_miss_a || w_miss_b;
        if (w_miss_a) begin
          w_state_nxt     = FILL_A;
          w_fill_addr_nxt = w_addr_a;
          w_cnt_nxt       = CntInit;
        end else if (w_miss_b) begin
          w_state_nxt     = FILL_B;
          w_fill_addr_nxt = w_addr_b;
          w_cnt_nxt       = CntInit;
        end
      end
      FILL_A: begin
        stall_o = 1'b1;
        if (w_fill_done) begin
          if (w_miss_b && (w_addr_b != r_fill_addr)) begin
            w_state_nxt     = FILL_B;
            w_fill_addr_nxt = w_addr_b;
            w_cnt_nxt       = CntInit;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      FILL_B: begin
        stall_o = 1'b1;
        if (w_fill_done) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_fill_addr <= '0;
      r_victim    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fill_addr <= w_fill_addr_nxt;
      if (w_alloc_en) r_victim <= r_victim + IdxW'(1);
    end
  end

  assign dbg_state_o = r_state;

`ifdef IBEX_RF_CACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic [32:0] w_hit_sum;

  assign w_hit_sum = {1'b0, r_hit_cnt} + {32'd0, w_rd_a_en} + {32'd0, w_rd_b_en};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (!stall_o) r_hit_cnt <= w_hit_sum[32] ? '1 : w_hit_sum[31:0];
      if (w_alloc_en && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_ibex_regfile_cached.sv
// Randomised bench for ibex_regfile_cached against a tag-list cache model and a flat register array.
module tb_ibex_regfile_cached;
  localparam int ML = 2;
  localparam int CE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re_a, re_b, we, flush;
  logic [4:0]  raddr_a, raddr_b, waddr;
  logic [31:0] rdata_a, rdata_b, wdata;
  logic        stall;
  ibex_rf_cache_pkg::rf_cache_state_e dbg_state;
`ifdef IBEX_RF_CACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  ibex_regfile_cached #(
    .RV32E(1'b0), .DataWidth(32), .CacheEntries(CE), .MissLatency(ML)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .re_a_i(re_a), .raddr_a_i(raddr_a), .rdata_a_o(rdata_a),
    .re_b_i(re_b), .raddr_b_i(raddr_b), .rdata_b_o(rdata_b),
    .we_a_i(we), .waddr_a_i(waddr), .wdata_a_i(wdata),
    .flush_i(flush), .stall_o(stall),
`ifdef IBEX_RF_CACHE_PERF_EN
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [32];
  logic [4:0]  c_tag [CE];
  bit          c_val [CE];
  int          c_ptr = 0;
  logic [31:0] exp_hit = 0;
  logic [31:0] exp_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit c_hit(input logic [4:0] a);
    for (int i = 0; i < CE; i++) if (c_val[i] && c_tag[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic c_alloc(input logic [4:0] a);
    c_tag[c_ptr] = a;
    c_val[c_ptr] = 1'b1;
    c_ptr = (c_ptr + 1) % CE;
  endtask

  task automatic c_clear();
    for (int i = 0; i < CE; i++) c_val[i] = 1'b0;
  endtask

  // Each round: one detect cycle, ML cycles per fill, B filled after A only if it missed beforehand.
  task automatic model_run(input bit ea, input logic [4:0] a, input bit eb, input logic [4:0] b,
                           output int st, output int fills);
    bit ma, mb;
    st = 0;
    fills = 0;
    for (int it = 0; it < 8; it++) begin
      ma = ea && a != 0 && !c_hit(a);
      mb = eb && b != 0 && !c_hit(b);
      if (!ma && !mb) break;
      st += 1 + ML;
      fills++;
      if (ma) begin
        c_alloc(a);
        if (mb && b != a) begin
          st += ML;
          c_alloc(b);
          fills++;
        end
      end else begin
        c_alloc(b);
      end
    end
  endtask

  task automatic perf_check();
`ifdef IBEX_RF_CACHE_PERF_EN
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
`endif
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    perf_check();
    re_a = 0; re_b = 0; we = 0; flush = 0;
    @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_rdata_a", rdata_a, 32'd0);
    check("idle_rdata_b", rdata_b, 32'd0);
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    perf_check();
    re_a = 0; re_b = 0; we = 0; flush = 1;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    c_clear();
  endtask

  // Write cycle; port A reads ra in the same cycle only if the model says it hits (no stall).
  task automatic do_write(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    bit rd;
    @(posedge clk); #1;
    perf_check();
    rd = (ra != 0) && c_hit(ra);
    re_a = rd; raddr_a = ra; re_b = 0; raddr_b = 5'($urandom_range(0, 31));
    we = 1; waddr = wa; wdata = wd; flush = 0;
    @(negedge clk);
    check("wr_stall", {31'd0, stall}, 32'd0);
    check("wr_rdata_old", rdata_a, rd ? mem[ra] : 32'd0);
    exp_hit += 32'(rd);
    if (wa != 0) mem[wa] = wd;
  endtask

  task automatic do_read(input bit ea, input logic [4:0] a, input bit eb, input logic [4:0] b,
                         input int flush_at);
    logic [31:0] c0_a, c0_b;
    int exp_stall, st, fills, n_stall, cyc;
    @(posedge clk); #1;
    perf_check();
    re_a = ea; raddr_a = a; re_b = eb; raddr_b = b; we = 0; flush = 0;
    c0_a = (ea && a != 0 && c_hit(a)) ? mem[a] : 32'd0;
    c0_b = (eb && b != 0 && c_hit(b)) ? mem[b] : 32'd0;
    exp_stall = 0;
    if (flush_at >= 0) begin
      exp_stall = flush_at + 1;
      c_clear();
    end
    model_run(ea, a, eb, b, st, fills);
    exp_stall += st;
    exp_q.push_back((ea && a != 0) ? mem[a] : 32'd0);
    exp_q.push_back((eb && b != 0) ? mem[b] : 32'd0);
    cyc = 0;
    n_stall = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        check("rdata_a_first", rdata_a, c0_a);
        check("rdata_b_first", rdata_b, c0_b);
      end
      if (!stall) break;
      n_stall++;
      if (n_stall > 64) begin
        check("stall_timeout", 32'(n_stall), 32'(exp_stall));
        break;
      end
      @(posedge clk); #1;
      flush = (cyc + 1 == flush_at);
      cyc++;
    end
    flush = 0;
    check("stall_cycles", 32'(n_stall), 32'(exp_stall));
    check("rdata_a", rdata_a, exp_q.pop_front());
    check("rdata_b", rdata_b, exp_q.pop_front());
    exp_hit  += 32'(ea && a != 0) + 32'(eb && b != 0);
    exp_miss += 32'(fills);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    c_clear();
    rst_n = 0; re_a = 0; re_b = 0; we = 0; flush = 0;
    raddr_a = 0; raddr_b = 0; waddr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata_a", rdata_a, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1;
    do_idle();

    do_write(5'd5, 32'h1234, 5'd0);
    do_read(1, 5'd5, 0, 5'd0, -1);
    do_read(1, 5'd3, 1, 5'd7, -1);
    do_read(1, 5'd3, 1, 5'd7, -1);
    do_write(5'd3, 32'hAA, 5'd3);
    do_read(1, 5'd3, 0, 5'd0, -1);
    do_write(5'd9, 32'h9999, 5'd0);
    do_read(1, 5'd9, 0, 5'd0, -1);

    do_flush();
    for (int r = 1; r <= 5; r++) do_read(1, 5'(r), 0, 5'd0, -1);
    do_read(1, 5'd2, 0, 5'd0, -1);
    do_read(1, 5'd1, 0, 5'd0, -1);

    do_write(5'd10, 32'hCAFE, 5'd0);
    do_read(1, 5'd10, 0, 5'd0, ML);
    do_read(1, 5'd10, 0, 5'd0, -1);
    do_read(1, 5'd0, 1, 5'd0, -1);
    do_write(5'd6, 32'h66, 5'd0);
    do_read(1, 5'd6, 1, 5'd6, -1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_read(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 12)),
                               1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 12)), -1);
        5, 6, 7: do_write(5'($urandom_range(0, 12)), $urandom, 5'($urandom_range(0, 12)));
        8: do_flush();
        default: do_idle();
      endcase
    end
    do_idle();
    perf_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
